// File: rtl/serial_byte_framer.sv
// Serial sync-word hunter and MSB-first byte deserializer feeding a small valid/ready FIFO.
// Optional per-byte even parity bit is compiled in with `define FRAMER_PARITY_EN.
module serial_byte_framer #(
    parameter logic [7:0] SYNC_WORD  = 8'hA5,
    parameter int         FRAME_LEN  = 4,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          clear,
    input  logic                          bit_in,
    input  logic                          bit_stb,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          in_sync,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          par_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
    localparam logic [7:0]    LAST = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY} state_t;

    state_t        state;
    logic [7:0]    window, shreg, byte_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_nxt;
    logic [7:0]    byte_new, win_new, push_data;
    logic          acc, push_req, byte_end, pop, do_push;
`ifdef FRAMER_PARITY_EN
    logic          par_bad;
`endif

    assign out_data = mem[rd_ptr];

    always_comb begin
        acc       = bit_stb && ena && !clear;
        byte_new  = {shreg[6:0], bit_in};
        win_new   = {window[6:0], bit_in};
        push_req  = 1'b0;
        byte_end  = 1'b0;
        push_data = byte_new;
`ifdef FRAMER_PARITY_EN
        par_bad   = 1'b0;
        // Parity bit closes the byte; shreg already holds the 8 data bits.
        if (acc && state == PARITY) begin
            byte_end  = 1'b1;
            push_data = shreg;
            if (^{shreg, bit_in}) par_bad = 1'b1;
            else                  push_req = 1'b1;
        end
`else
        if (acc && state == PAYLOAD && bit_cnt == 3'd7) begin
            byte_end = 1'b1;
            push_req = 1'b1;
        end
`endif
        pop       = out_valid && out_ready;
        do_push   = push_req && (fifo_level != FULL || pop);
        level_nxt = fifo_level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            window     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            in_sync    <= 1'b0;
            frame_done <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            par_err    <= 1'b0;
            if (clear) begin
                state    <= HUNT;
                window   <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                in_sync  <= 1'b0;
            end else if (acc) begin
                case (state)
                    HUNT: begin
                        if (win_new == SYNC_WORD) begin
                            state    <= PAYLOAD;
                            in_sync  <= 1'b1;
                            window   <= '0;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                        end else begin
                            window <= win_new;
                        end
                    end
                    PAYLOAD: begin
                        shreg   <= byte_new;
                        bit_cnt <= bit_cnt + 3'd1;
`ifdef FRAMER_PARITY_EN
                        if (bit_cnt == 3'd7) state <= PARITY;
`endif
                    end
                    PARITY: begin
                        state <= PAYLOAD;
`ifdef FRAMER_PARITY_EN
                        par_err <= par_bad;
`endif
                    end
                    default: state <= HUNT;
                endcase
                // Bytes count toward the frame even when dropped or parity-rejected.
                if (byte_end) begin
                    if (byte_cnt == LAST) begin
                        frame_done <= 1'b1;
                        state      <= HUNT;
                        in_sync    <= 1'b0;
                        window     <= '0;
                        byte_cnt   <= '0;
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !do_push) overflow <= 1'b1;
            fifo_level <= level_nxt;
            out_valid  <= (level_nxt != '0);
        end
    end
endmodule

// File: tb/tb_serial_byte_framer.sv
// Directed bench for serial_byte_framer: sync hunt, framing, FIFO full/overflow, reset, parity.
module tb_serial_byte_framer;
    logic clk = 0, rst_n = 0, ena = 0, clear = 0, bit_in = 0, bit_stb = 0, out_ready = 0;
    logic [7:0] out_data;
    logic out_valid, in_sync, frame_done, overflow, par_err;
    logic [2:0] fifo_level;
    int total = 0, bad = 0, fd_cnt = 0, pe_cnt = 0;
    logic [7:0] rx[$];

    serial_byte_framer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .bit_in(bit_in), .bit_stb(bit_stb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .in_sync(in_sync),
        .frame_done(frame_done), .overflow(overflow), .par_err(par_err), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Record every handshake and status pulse half a cycle ahead of the consuming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready && !clear) rx.push_back(out_data);
            if (frame_done) fd_cnt++;
            if (par_err) pe_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Gap cycles carry an ena=0 strobe and idle cycles that must both be ignored.
    task automatic send_bit(input logic b, input int gap);
        bit_in = b; bit_stb = 1; ena = 1;
        tick();
        bit_stb = 0;
        for (int i = 0; i < gap; i++) begin
            ena = 0; bit_stb = (i == 1); bit_in = ~b;
            tick();
        end
        ena = 1; bit_stb = 0;
    endtask

    task automatic send_raw(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        send_raw(b, gap);
`ifdef FRAMER_PARITY_EN
        send_bit(^b, gap);
`endif
    endtask

    // Holds out_ready high only on the cycle whose edge pushes the byte.
    task automatic send_byte_pop(input logic [7:0] b);
`ifdef FRAMER_PARITY_EN
        send_raw(b, 0);
        out_ready = 1;
        send_bit(^b, 0);
`else
        for (int i = 7; i >= 1; i--) send_bit(b[i], 0);
        out_ready = 1;
        send_bit(b[0], 0);
`endif
        out_ready = 0;
    endtask

    task automatic do_clear();
        clear = 1; tick(); clear = 0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out_valid !== 1'b0 || in_sync !== 1'b0 || frame_done !== 1'b0) begin
            $display("FAIL reset_ctl: valid=%b sync=%b fd=%b want 0", out_valid, in_sync, frame_done); bad++; end
        total++; if (overflow !== 1'b0 || par_err !== 1'b0 || fifo_level !== 3'd0 || out_data !== 8'h00) begin
            $display("FAIL reset_stat: ovf=%b pe=%b lvl=%0d data=%h want 0", overflow, par_err, fifo_level, out_data); bad++; end
        tick(); tick(); rst_n = 1; tick();
    endtask

    task automatic test_frame();
        logic [7:0] exp [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        rx.delete(); fd_cnt = 0; pe_cnt = 0; out_ready = 1;
        send_raw(8'hA5, 0);
        total++; if (in_sync !== 1'b1) begin $display("FAIL frame_sync: in_sync=%b want 1", in_sync); bad++; end
        for (int i = 0; i < 4; i++) send_byte(exp[i], 0);
        total++; if (frame_done !== 1'b1) begin $display("FAIL frame_done_pulse: %b want 1", frame_done); bad++; end
        total++; if (in_sync !== 1'b0) begin $display("FAIL frame_sync_fall: in_sync=%b want 0", in_sync); bad++; end
        tick();
        total++; if (frame_done !== 1'b0) begin $display("FAIL frame_done_width: %b want 0", frame_done); bad++; end
        tick(); tick();
        total++; if (rx.size() != 4) begin $display("FAIL frame_count: got %0d want 4", rx.size()); bad++; end
        else for (int i = 0; i < 4; i++) begin
            total++; if (rx[i] !== exp[i]) begin $display("FAIL frame_data[%0d]: got %h want %h", i, rx[i], exp[i]); bad++; end
        end
        total++; if (fd_cnt != 1 || overflow !== 1'b0 || pe_cnt != 0) begin
            $display("FAIL frame_status: fd=%0d ovf=%b pe=%0d want 1/0/0", fd_cnt, overflow, pe_cnt); bad++; end
    endtask

    task automatic test_hunt_gaps();
        logic [7:0] exp [4] = '{8'hA5, 8'h00, 8'hFF, 8'h81};
        logic [7:0] sw = 8'hA5;
        logic saw = 0;
        rx.delete(); fd_cnt = 0; out_ready = 1;
        send_raw(8'h5A, 3); saw |= in_sync;
        send_raw(8'h3C, 3); saw |= in_sync;
        for (int i = 7; i >= 1; i--) begin send_bit(sw[i], 3); saw |= in_sync; end
        total++; if (saw !== 1'b0) begin $display("FAIL hunt_early: in_sync seen=%b want 0", saw); bad++; end
        send_bit(sw[0], 0);
        total++; if (in_sync !== 1'b1) begin $display("FAIL hunt_sync: in_sync=%b want 1", in_sync); bad++; end
        for (int i = 0; i < 4; i++) send_byte(exp[i], 3);
        tick(); tick();
        total++; if (rx.size() != 4) begin $display("FAIL hunt_count: got %0d want 4", rx.size()); bad++; end
        else for (int i = 0; i < 4; i++) begin
            total++; if (rx[i] !== exp[i]) begin $display("FAIL hunt_data[%0d]: got %h want %h", i, rx[i], exp[i]); bad++; end
        end
        total++; if (fd_cnt != 1 || in_sync !== 1'b0) begin
            $display("FAIL hunt_status: fd=%0d sync=%b want 1/0", fd_cnt, in_sync); bad++; end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        rx.delete(); out_ready = 0;
        send_raw(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(exp[i], 0);
        total++; if (fifo_level !== 3'd4 || overflow !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL ovf_fill: lvl=%0d ovf=%b valid=%b want 4/0/1", fifo_level, overflow, out_valid); bad++; end
        send_raw(8'hA5, 0);
        send_byte(8'h55, 0);
        total++; if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            $display("FAIL ovf_drop: lvl=%0d ovf=%b want 4/1", fifo_level, overflow); bad++; end
        out_ready = 1;
        for (int i = 0; i < 6; i++) tick();
        out_ready = 0;
        total++; if (rx.size() != 4) begin $display("FAIL ovf_count: got %0d want 4", rx.size()); bad++; end
        else for (int i = 0; i < 4; i++) begin
            total++; if (rx[i] !== exp[i]) begin $display("FAIL ovf_data[%0d]: got %h want %h", i, rx[i], exp[i]); bad++; end
        end
        total++; if (overflow !== 1'b1 || fifo_level !== 3'd0) begin
            $display("FAIL ovf_sticky: ovf=%b lvl=%0d want 1/0", overflow, fifo_level); bad++; end
        do_clear();
        total++; if (overflow !== 1'b0 || fifo_level !== 3'd0 || in_sync !== 1'b0) begin
            $display("FAIL ovf_clear: ovf=%b lvl=%0d sync=%b want 0/0/0", overflow, fifo_level, in_sync); bad++; end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [5] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h9C};
        rx.delete(); out_ready = 0;
        send_raw(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(exp[i], 0);
        send_raw(8'hA5, 0);
        send_byte_pop(8'h9C);
        total++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            $display("FAIL fpp_level: lvl=%0d ovf=%b want 4/0", fifo_level, overflow); bad++; end
        out_ready = 1;
        for (int i = 0; i < 6; i++) tick();
        out_ready = 0;
        total++; if (rx.size() != 5) begin $display("FAIL fpp_count: got %0d want 5", rx.size()); bad++; end
        else for (int i = 0; i < 5; i++) begin
            total++; if (rx[i] !== exp[i]) begin $display("FAIL fpp_data[%0d]: got %h want %h", i, rx[i], exp[i]); bad++; end
        end
        do_clear();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        logic [7:0] part = 8'hF0;
        rx.delete(); fd_cnt = 0; out_ready = 0;
        send_raw(8'hA5, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        for (int i = 7; i >= 4; i--) send_bit(part[i], 0);
        total++; if (fifo_level !== 3'd2 || in_sync !== 1'b1) begin
            $display("FAIL rstm_pre: lvl=%0d sync=%b want 2/1", fifo_level, in_sync); bad++; end
        #2 rst_n = 0; #1;
        total++; if (out_valid !== 1'b0 || fifo_level !== 3'd0 || in_sync !== 1'b0 || out_data !== 8'h00) begin
            $display("FAIL rstm_async: valid=%b lvl=%0d sync=%b data=%h want 0", out_valid, fifo_level, in_sync, out_data); bad++; end
        tick(); rst_n = 1; tick();
        out_ready = 1;
        send_raw(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(exp[i], 0);
        tick(); tick();
        total++; if (rx.size() != 4) begin $display("FAIL rstm_count: got %0d want 4", rx.size()); bad++; end
        else for (int i = 0; i < 4; i++) begin
            total++; if (rx[i] !== exp[i]) begin $display("FAIL rstm_data[%0d]: got %h want %h", i, rx[i], exp[i]); bad++; end
        end
        total++; if (fd_cnt != 1) begin $display("FAIL rstm_fd: got %0d want 1", fd_cnt); bad++; end
    endtask

`ifdef FRAMER_PARITY_EN
    task automatic test_parity();
        rx.delete(); fd_cnt = 0; pe_cnt = 0; out_ready = 1;
        send_raw(8'hA5, 0);
        send_raw(8'h12, 0); send_bit(1'b0, 0);
        total++; if (par_err !== 1'b0) begin $display("FAIL par_good: par_err=%b want 0", par_err); bad++; end
        send_raw(8'h34, 0); send_bit(1'b0, 0);
        total++; if (par_err !== 1'b1) begin $display("FAIL par_bad: par_err=%b want 1", par_err); bad++; end
        send_byte(8'h56, 0);
        total++; if (frame_done !== 1'b0) begin $display("FAIL par_early_fd: %b want 0", frame_done); bad++; end
        send_byte(8'h78, 0);
        total++; if (frame_done !== 1'b1) begin $display("FAIL par_fd: %b want 1", frame_done); bad++; end
        tick(); tick();
        total++; if (rx.size() != 3 || pe_cnt != 1) begin
            $display("FAIL par_count: got %0d bytes %0d errs want 3/1", rx.size(), pe_cnt); bad++; end
        else begin
            total++; if (rx[0] !== 8'h12 || rx[1] !== 8'h56 || rx[2] !== 8'h78) begin
                $display("FAIL par_data: got %h %h %h want 12 56 78", rx[0], rx[1], rx[2]); bad++; end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_hunt_gaps();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
`ifdef FRAMER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
